// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage in-order core: load-use and branch
// hazard control, data-memory miss freeze FSM with timeout, perf counters.
//
// state    | meaning
// RUN      | normal flow, hazards resolved each cycle
// MEM_WAIT | data-memory miss outstanding, whole pipe frozen
// ERROR    | miss outlasted MAX_WAIT, pipe frozen until reset
module pipeline_hazard_controller #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_takebranch,
  input  logic [31:0]      ex_target,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_ex,
  output logic             bubble_wb,
  output logic             flush_id,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [1:0]       state_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 2 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              freeze, redirect, load_use, src_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (MAX_WAIT != 0 && wait_cnt == WAIT_W'(MAX_WAIT)) begin
          state_nxt    = ERROR;
          wait_cnt_nxt = '0;
        end else if (wait_cnt != '1) begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RUN;
    endcase
  end

  // A redirect squashes the ID instruction, so it masks any load-use match.
  always_comb begin
    freeze    = (state == ERROR) ||
                (state == MEM_WAIT && !mem_ready) ||
                (state == RUN && mem_req && !mem_ready);
    src_match = (id_uses_rs1 && id_rs1 == ex_rd) ||
                (id_uses_rs2 && id_rs2 == ex_rd);
    redirect  = !freeze && ex_valid && ex_takebranch;
    load_use  = !freeze && !redirect && id_valid && ex_valid && ex_is_load &&
                (ex_rd != 5'd0) && src_match;

    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    bubble_ex      = 1'b0;
    bubble_wb      = 1'b0;
    flush_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if (!reset) begin
      stall_if       = freeze || load_use;
      stall_id       = freeze || load_use;
      stall_ex       = freeze;
      stall_mem      = freeze;
      bubble_ex      = redirect || load_use;
      bubble_wb      = freeze;
      flush_id       = redirect;
      redirect_valid = redirect;
      redirect_pc    = redirect ? ex_target : 32'd0;
    end
  end

  assign state_o = state;
  assign error_o = (state == ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_if && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (redirect_valid && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed and random
// stimulus, expected responses from a behavioural model, popped by a monitor.
module tb_pipeline_hazard_controller;

  localparam int MAXW  = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0;
  logic [4:0]  id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic        ex_valid = 0, ex_is_load = 0, ex_takebranch = 0;
  logic [31:0] ex_target = 0;
  logic        mem_req = 0, mem_ready = 0;
  logic        stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb;
  logic        flush_id, redirect_valid, error_o;
  logic [31:0] redirect_pc;
  logic [1:0]  state_o;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_controller #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_takebranch(ex_takebranch), .ex_target(ex_target),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .bubble_ex(bubble_ex), .bubble_wb(bubble_wb),
    .flush_id(flush_id), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .state_o(state_o), .error_o(error_o),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        idv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        exv;
    logic        ld;
    logic [4:0]  rd;
    logic        tb;
    logic [31:0] tgt;
    logic        req;
    logic        rdy;
  } stim_t;

  typedef struct packed {
    logic        full;
    logic [7:0]  ctrl;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        err;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0, fails = 0;
  bit   running = 0;

  // reference model state: miss cycles elapsed (0 = no miss), error flag
  int   m_wait = 0;
  bit   m_err = 0, m_known = 0;
  int   m_stall = 0, m_flush = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_push(input stim_t s);
    exp_t e;
    bit frz, redir, lu, match;
    e = '0;
    e.full = !s.rst && m_known;
    if (!s.rst) begin
      frz   = m_err || (m_wait > 0 ? !s.rdy : (s.req && !s.rdy));
      redir = !frz && s.exv && s.tb;
      match = (s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd);
      lu    = !frz && !redir && s.idv && s.exv && s.ld && s.rd != 0 && match;
      e.ctrl = {frz | lu, frz | lu, frz, frz, redir | lu, frz, redir, redir};
      e.pc   = redir ? s.tgt : 32'd0;
    end
    e.st  = m_err ? 2'b10 : (m_wait > 0 ? 2'b01 : 2'b00);
    e.err = m_err;
    e.sc  = CW'(m_stall);
    e.fc  = CW'(m_flush);
    exp_q.push_back(e);
    if (s.rst) begin
      m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_known = 1;
    end else begin
      if (e.ctrl[7] && m_stall < CMAX) m_stall++;
      if (e.ctrl[0] && m_flush < CMAX) m_flush++;
      if (!m_err) begin
        if (m_wait > 0) begin
          if (s.rdy) m_wait = 0;
          else if (m_wait == MAXW) begin m_err = 1; m_wait = 0; end
          else m_wait++;
        end else if (s.req && !s.rdy) m_wait = 1;
      end
    end
  endtask

  task automatic cycle(input stim_t s);
    @(posedge clk);
    #1;
    reset = s.rst; id_valid = s.idv; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_valid = s.exv; ex_is_load = s.ld;
    ex_rd = s.rd; ex_takebranch = s.tb; ex_target = s.tgt;
    mem_req = s.req; mem_ready = s.rdy;
    model_push(s);
  endtask

  task automatic idle(input int n);
    stim_t s;
    s = '0;
    for (int i = 0; i < n; i++) cycle(s);
  endtask

  task automatic do_reset();
    stim_t s;
    s = '0; s.rst = 1;
    cycle(s);
  endtask

  // monitor: one expected entry per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ctrl", 32'({stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
                          bubble_wb, flush_id, redirect_valid}), 32'(e.ctrl));
        check("redirect_pc", redirect_pc, e.pc);
        if (e.full) begin
          check("state_o", 32'(state_o), 32'(e.st));
          check("error_o", 32'(error_o), 32'(e.err));
          check("stall_count", 32'(stall_count), 32'(e.sc));
          check("flush_count", 32'(flush_count), 32'(e.fc));
        end
      end else if (running) begin
        tests++; fails++;
        $display("FAIL scoreboard: no expected entry at %0t", $time);
      end
    end
  end

  initial begin
    stim_t s, lu_s;
    running = 1;
    do_reset(); do_reset();
    idle(1);

    lu_s = '0;
    lu_s.idv = 1; lu_s.exv = 1; lu_s.ld = 1; lu_s.rd = 5; lu_s.rs1 = 5; lu_s.u1 = 1;
    cycle(lu_s); idle(1);
    s = lu_s; s.rd = 0; s.rs1 = 0; cycle(s); idle(1);
    s = lu_s; s.rs1 = 1; s.rs2 = 5; s.u2 = 1; cycle(s); idle(1);

    s = lu_s; s.tb = 1; s.tgt = 32'h100; cycle(s); idle(1);

    do_reset();
    s = '0; s.exv = 1; s.tb = 1; s.tgt = 32'h240; s.req = 1; s.rdy = 0;
    for (int i = 0; i < 3; i++) cycle(s);
    s.rdy = 1; cycle(s); idle(2);

    do_reset();
    s = '0; s.req = 1; s.rdy = 0; s.exv = 1; s.tb = 1; s.tgt = 32'h3c;
    for (int i = 0; i < 25; i++) cycle(s);
    s.rdy = 1; cycle(s);
    do_reset(); idle(2);

    s = '0; s.req = 1; s.rdy = 0;
    cycle(s); cycle(s);
    s.rst = 1; cycle(s);
    idle(2);

    for (int i = 0; i < 20; i++) cycle(lu_s);
    s = '0; s.exv = 1; s.tb = 1; s.tgt = 32'hdead_beef;
    for (int i = 0; i < 20; i++) cycle(s);
    idle(2);

    for (int i = 0; i < 800; i++) begin
      s.rst = ($urandom % 50) == 0;
      s.idv = ($urandom % 4) != 0;
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.u1  = $urandom % 2;
      s.u2  = $urandom % 2;
      s.exv = ($urandom % 4) != 0;
      s.ld  = $urandom % 2;
      s.rd  = 5'($urandom_range(0, 3));
      s.tb  = ($urandom % 5) == 0;
      s.tgt = $urandom;
      s.req = ($urandom % 3) == 0;
      s.rdy = ($urandom % 3) != 0;
      cycle(s);
    end

    @(negedge clk);
    #1;
    running = 0;
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
